// File: rtl/mem_responder.sv
// Fixed-latency backing memory: answers a cache miss DELAY cycles after the
// rising edge of enable, holding the response until enable drops.
module mem_responder #(
   parameter int ADDR_LENGTH = 10,
   parameter int DELAY       = 10,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_LENGTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   we,
   input  logic                   enable,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   requestComplete,
   output logic                   busy
);

   localparam int WORDS = 2 ** (ADDR_LENGTH - 2);
   localparam int CW    = $clog2(DELAY + 1);
   localparam int IW    = ADDR_LENGTH - 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESPOND
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  en_q;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  rc_q, rc_d;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] mem_q [WORDS];

   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      rc_d    = rc_q;
      wr_en   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // only a fresh rising edge of enable starts a request
            if (enable && !en_q) begin
               idx_d   = addr[ADDR_LENGTH-1:2];
               we_d    = we;
               wdata_d = data_in;
               cnt_d   = CW'(DELAY - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESPOND;
               rc_d    = 1'b1;
               if (we_q) begin
                  wr_en  = 1'b1;
                  dout_d = wdata_q;
               end else begin
                  dout_d = mem_q[idx_q];
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RESPOND: begin
            if (!enable) begin
               rc_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         dout_q  <= '0;
         rc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= enable;
         idx_q   <= idx_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         rc_q    <= rc_d;
      end
   end

   // word k powers up holding its own byte address
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < WORDS; k++) begin
            mem_q[k] <= DATA_WIDTH'(k * 4);
         end
      end else if (wr_en) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign data_out        = dout_q;
   assign requestComplete = rc_q;
   assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: DELAY=10 main instance plus a DELAY=1
// instance for the minimum-latency case.
module tb_mem_responder;

   localparam int D = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  addr;
   logic [31:0] data_in;
   logic        we;
   logic        enable;
   logic [31:0] data_out;
   logic        rc;
   logic        busy;

   logic [9:0]  addr1;
   logic        enable1;
   logic [31:0] data_out1;
   logic        rc1;
   logic        busy1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_LENGTH(10), .DELAY(D), .DATA_WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .addr(addr),
      .data_in(data_in),
      .we(we),
      .enable(enable),
      .data_out(data_out),
      .requestComplete(rc),
      .busy(busy)
   );

   mem_responder #(.ADDR_LENGTH(10), .DELAY(1), .DATA_WIDTH(32)) dut1 (
      .clk(clk),
      .reset(reset),
      .addr(addr1),
      .data_in(32'h0),
      .we(1'b0),
      .enable(enable1),
      .data_out(data_out1),
      .requestComplete(rc1),
      .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input string tag, input logic [9:0] a,
                         input logic w, input logic [31:0] d,
                         input logic [31:0] exp, input int hold);
      addr    = a;
      we      = w;
      data_in = d;
      enable  = 1'b1;
      tick();
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      for (int i = 1; i < D; i++) begin
         tick();
         chk({tag, "_early"}, 32'(rc), 32'd0);
      end
      tick();
      chk({tag, "_rc"}, 32'(rc), 32'd1);
      chk({tag, "_data"}, data_out, exp);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_rc"}, 32'(rc), 32'd1);
         chk({tag, "_hold_data"}, data_out, exp);
      end
      enable = 1'b0;
      tick();
      chk({tag, "_drop_rc"}, 32'(rc), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset   = 1'b1;
      addr    = '0;
      data_in = '0;
      we      = 1'b0;
      enable  = 1'b0;
      addr1   = '0;
      enable1 = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_rc", 32'(rc), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", data_out, 32'd0);

      do_req("rd028", 10'h028, 1'b0, 32'h0, 32'h0000_0028, 3);
      do_req("wr040", 10'h040, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
      do_req("rd043", 10'h043, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
      do_req("rd044", 10'h044, 1'b0, 32'h0, 32'h0000_0044, 0);

      // inputs move and enable glitches during WAIT
      addr   = 10'h010;
      we     = 1'b0;
      enable = 1'b1;
      tick();
      addr = 10'h3FC;
      tick();
      chk("cap_early", 32'(rc), 32'd0);
      enable = 1'b0;
      tick();
      chk("cap_busy", 32'(busy), 32'd1);
      enable = 1'b1;
      for (int i = 3; i < D; i++) begin
         tick();
         chk("cap_early", 32'(rc), 32'd0);
      end
      tick();
      chk("cap_rc", 32'(rc), 32'd1);
      chk("cap_data", data_out, 32'h0000_0010);
      enable = 1'b0;
      tick();
      chk("cap_drop", 32'(rc), 32'd0);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("cap_no_second", 32'(busy | rc), 32'd0);
      end

      // reset aborts an in-flight write
      addr    = 10'h080;
      we      = 1'b1;
      data_in = 32'h1234_5678;
      enable  = 1'b1;
      tick();
      for (int i = 1; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      chk("rstmid_rc", 32'(rc), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      reset  = 1'b0;
      enable = 1'b0;
      tick();
      do_req("rd080", 10'h080, 1'b0, 32'h0, 32'h0000_0080, 0);

      // long level hold, then a re-request after one low edge
      do_req("hold", 10'h100, 1'b0, 32'h0, 32'h0000_0100, 100);
      do_req("rd004", 10'h004, 1'b0, 32'h0, 32'h0000_0004, 0);

      // DELAY=1 instance
      addr1   = 10'h3FC;
      enable1 = 1'b1;
      tick();
      chk("d1_accept_rc", 32'(rc1), 32'd0);
      chk("d1_busy", 32'(busy1), 32'd1);
      tick();
      chk("d1_rc", 32'(rc1), 32'd1);
      chk("d1_data", data_out1, 32'h0000_03FC);
      enable1 = 1'b0;
      tick();
      chk("d1_drop", 32'(rc1), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
